// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Brief    : Shared encodings for the memory responder: access sizes,
//            responder state and the big-endian lane-select helper.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Responder state, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    // Byte-lane enables for a big-endian access. Bit i enables data bits
    // [8i+7:8i]; byte k at addr[1:0] lives in lane 3-k. An illegal size
    // selects no lanes.
    function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b1000 >> addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Brief    : Combinational big-endian lane steering. Extracts and extends
//            load data from a stored word, and shifts right-aligned store
//            data into its lanes with matching byte enables.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed_ld,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata_lane,
    output logic [31:0] o_rdata_ext
);

    logic [4:0]  w_shamt;
    logic [31:0] w_rshift;

    // Bit distance between the selected lane(s) and bit 0 of the word
    always_comb begin
        w_shamt = 5'd0;
        case (i_size)
            SZ_BYTE: w_shamt = {~i_addr_lo, 3'b000};   // 8*(3-k)
            SZ_HALF: w_shamt = i_addr_lo[1] ? 5'd0 : 5'd16;
            default: w_shamt = 5'd0;
        endcase
    end

    assign o_byte_en    = lane_sel(i_size, i_addr_lo);
    // Bits beyond the access width land in disabled lanes and are masked off
    assign o_wdata_lane = i_wdata << w_shamt;
    assign w_rshift     = i_rword >> w_shamt;

    // Right-align the loaded lanes and sign- or zero-extend them
    always_comb begin
        o_rdata_ext = w_rshift;
        case (i_size)
            SZ_BYTE: o_rdata_ext = {{24{i_signed_ld & w_rshift[7]}},  w_rshift[7:0]};
            SZ_HALF: o_rdata_ext = {{16{i_signed_ld & w_rshift[15]}}, w_rshift[15:0]};
            default: o_rdata_ext = w_rshift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Single-outstanding memory responder with programmable wait
//            states. Performs big-endian byte/half/word accesses on an
//            internal word array and returns a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int               c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam bit               c_ZERO_WAIT = (WAIT_CYCLES == 0);

    // FSM state, wait counter and registered outputs
    resp_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic             r_busy;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [31:0]      r_resp_rdata;

    // Request captured at acceptance
    logic             r_write;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    // Storage; intentionally not cleared by reset
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_in_idle;
    logic             w_accept;
    logic             w_a_write;
    logic [1:0]       w_a_size;
    logic             w_a_signed;
    logic [31:0]      w_a_addr;
    logic [31:0]      w_a_wdata;
    logic             w_misalign;
    logic             w_oor;
    logic             w_illegal;
    logic             w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]      w_rword;
    logic [3:0]       w_be;
    logic [31:0]      w_mask;
    logic [31:0]      w_wdata_lane;
    logic [31:0]      w_load_data;
    logic [31:0]      w_merged;
    logic             w_enter_resp;
    logic             w_commit;

    assign w_in_idle = (r_state == ST_IDLE);
    assign w_accept  = req_valid && r_req_ready;

    // With zero wait states the access happens on the accepting edge, before
    // the request registers are loaded, so the live inputs are used there.
    assign w_a_write  = w_in_idle ? req_write  : r_write;
    assign w_a_size   = w_in_idle ? req_size   : r_size;
    assign w_a_signed = w_in_idle ? req_signed : r_signed;
    assign w_a_addr   = w_in_idle ? req_addr   : r_addr;
    assign w_a_wdata  = w_in_idle ? req_wdata  : r_wdata;

    assign w_illegal  = (w_a_size == SZ_ILLEGAL);
    assign w_misalign = ((w_a_size == SZ_HALF) && w_a_addr[0]) ||
                        ((w_a_size == SZ_WORD) && (w_a_addr[1:0] != 2'b00));
    // Full 30-bit index compare so nonzero upper address bits never alias
    assign w_oor      = ({2'b00, w_a_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err      = w_illegal || w_misalign || w_oor;

    assign w_idx      = w_a_addr[c_IDX_W+1:2];
    assign w_rword    = r_mem[w_idx];

    mem_lane_align u_lane_align (
        .i_size       (w_a_size),
        .i_signed_ld  (w_a_signed),
        .i_addr_lo    (w_a_addr[1:0]),
        .i_wdata      (w_a_wdata),
        .i_rword      (w_rword),
        .o_byte_en    (w_be),
        .o_wdata_lane (w_wdata_lane),
        .o_rdata_ext  (w_load_data)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
        assign w_mask[8*gi +: 8] = {8{w_be[gi]}};
    end

    assign w_merged = (w_rword & ~w_mask) | (w_wdata_lane & w_mask);

    // The edge entering RESP is the single access point for reads and writes
    assign w_enter_resp = w_in_idle ? (w_accept && c_ZERO_WAIT)
                                    : ((r_state == ST_WAIT) && (r_cnt == '0));
    // Reset on the access edge suppresses the commit
    assign w_commit     = w_enter_resp && w_a_write && !w_err && !reset;

    // Control FSM: accept, count down wait states, emit one response pulse.
    // WAIT runs the counter down to zero and leaves on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_enter_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || w_a_write) ? '0 : w_load_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (c_ZERO_WAIT) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Word write-back; disabled lanes keep their previous contents
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder with two
//            instances: WAIT_CYCLES = 2 and WAIT_CYCLES = 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with two wait states
    logic        rst2, v2, w2, s2, rdy2, rv2, er2, bsy2;
    logic [1:0]  sz2;
    logic [31:0] a2, d2, rd2;
    // Instance with zero wait states
    logic        rst0, v0, w0, s0, rdy0, rv0, er0, bsy0;
    logic [1:0]  sz0;
    logic [31:0] a0, d0, rd0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .CNT_W(8)) dut2 (
        .clk(clk), .reset(rst2), .req_valid(v2), .req_ready(rdy2),
        .req_write(w2), .req_size(sz2), .req_signed(s2), .req_addr(a2),
        .req_wdata(d2), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2),
        .busy(bsy2)
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(rst0), .req_valid(v0), .req_ready(rdy0),
        .req_write(w0), .req_size(sz0), .req_signed(s0), .req_addr(a0),
        .req_wdata(d0), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0),
        .busy(bsy0)
    );

    // One request on dut2; lat = edges from acceptance to visible resp_valid
    task automatic req2(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (rdy2 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        w2 = w; sz2 = sz; s2 = sg; a2 = a; d2 = d; v2 = 1'b1;
        @(posedge clk); #1; v2 = 1'b0;
        lat = 0;
        while (rv2 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rd2; er = er2;
    endtask

    task automatic req0(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (rdy0 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        w0 = w; sz0 = sz; s0 = sg; a0 = a; d0 = d; v0 = 1'b1;
        @(posedge clk); #1; v0 = 1'b0;
        lat = 0;
        while (rv0 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rd0; er = er0;
    endtask

    task automatic test_reset();
        rst2 = 1'b1; rst0 = 1'b1;
        v2 = 0; w2 = 0; sz2 = 2'b10; s2 = 0; a2 = 0; d2 = 0;
        v0 = 0; w0 = 0; sz0 = 2'b10; s0 = 0; a0 = 0; d0 = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if ({rdy2, bsy2, rv2, er2} !== 4'b1000) $display("FAIL reset_ctrl2 got %b exp 1000", {rdy2, bsy2, rv2, er2}); else n_pass++;
        n_checks++; if (rd2 !== 32'h0) $display("FAIL reset_rdata2 got %h exp 00000000", rd2); else n_pass++;
        n_checks++; if ({rdy0, bsy0, rv0, er0, rd0} !== {4'b1000, 32'h0}) $display("FAIL reset_all0 got %b_%h exp 1000_00000000", {rdy0, bsy0, rv0, er0}, rd0); else n_pass++;
        @(negedge clk); rst2 = 1'b0; rst0 = 1'b0;
    endtask

    task automatic test_word_store_load();
        int lows, lat, bsy_seen;
        logic [31:0] rd, st_rd;
        logic er, st_er;
        @(negedge clk);
        w2 = 1; sz2 = 2'b10; s2 = 0; a2 = 32'h10; d2 = 32'hDEADBEEF; v2 = 1'b1;
        @(posedge clk); #1; v2 = 1'b0;
        lows = 0; lat = -1; bsy_seen = 0; st_rd = 32'hFFFFFFFF; st_er = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rdy2 === 1'b0) lows++;
            if (i == 0 && bsy2 === 1'b1) bsy_seen = 1;
            if (rv2 === 1'b1 && lat < 0) begin lat = i; st_rd = rd2; st_er = er2; end
            @(posedge clk); #1;
        end
        n_checks++; if (lows != 4) $display("FAIL store_ready_low got %0d exp 4", lows); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL store_latency got %0d exp 3", lat); else n_pass++;
        n_checks++; if (bsy_seen != 1) $display("FAIL busy_in_wait got %0d exp 1", bsy_seen); else n_pass++;
        n_checks++; if ({st_er, st_rd} !== {1'b0, 32'h0}) $display("FAIL store_resp got %b_%h exp 0_00000000", st_er, st_rd); else n_pass++;
        req2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL word_load got %h exp deadbeef", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL word_load_err got %b exp 0", er); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL load_latency got %0d exp 3", lat); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if ({rv2, rd2} !== {1'b0, 32'hDEADBEEF}) $display("FAIL rdata_hold got %b_%h exp 0_deadbeef", rv2, rd2); else n_pass++;
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic er;
        int lat;
        // Upper bits of wdata must not leak into other lanes
        req2(1'b1, 2'b00, 1'b0, 32'h12, 32'hABCDEF11, rd, er, lat);
        req2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD11EF) $display("FAIL byte_store_rb got %h exp dead11ef", rd); else n_pass++;
        req2(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_signed got %h exp ffffffde", rd); else n_pass++;
        req2(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h000000DE) $display("FAIL lb_unsigned got %h exp 000000de", rd); else n_pass++;
        req2(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h000000EF) $display("FAIL lbu_13 got %h exp 000000ef", rd); else n_pass++;
        req2(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h000011EF) $display("FAIL lh_signed_12 got %h exp 000011ef", rd); else n_pass++;
        req2(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFDEAD) $display("FAIL lh_signed_10 got %h exp ffffdead", rd); else n_pass++;
        req2(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0000DEAD) $display("FAIL lhu_10 got %h exp 0000dead", rd); else n_pass++;
        // Half store into the low half of 0x14 after a full word store
        req2(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFE0000, rd, er, lat);
        req2(1'b1, 2'b01, 1'b0, 32'h16, 32'h1234F00D, rd, er, lat);
        req2(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL half_store_rb got %h exp cafef00d", rd); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        req2(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_half_13 got %b_%h exp 1_00000000", er, rd); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL err_latency got %0d exp 3", lat); else n_pass++;
        req2(1'b1, 2'b10, 1'b0, 32'h16, 32'hFFFFFFFF, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_word_16 got %b_%h exp 1_00000000", er, rd); else n_pass++;
        req2(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_oor_load got %b_%h exp 1_00000000", er, rd); else n_pass++;
        req2(1'b1, 2'b11, 1'b0, 32'h14, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_size11 got %b_%h exp 1_00000000", er, rd); else n_pass++;
        req2(1'b1, 2'b10, 1'b0, 32'h80000014, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL err_upper_addr got %b_%h exp 1_00000000", er, rd); else n_pass++;
        req2(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== {1'b0, 32'hCAFEF00D}) $display("FAIL err_rb_14 got %b_%h exp 0_cafef00d", er, rd); else n_pass++;
        req2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD11EF) $display("FAIL err_rb_10 got %h exp dead11ef", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc, resp, bad, last_acc, g, lat;
        logic [31:0] rd;
        logic er;
        acc = 0; resp = 0; bad = 0; last_acc = -1; g = 0;
        @(negedge clk);
        while (rdy2 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        v2 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            if (rdy2 === 1'b1) begin
                acc++; last_acc = k;
                w2 = 1'b0; sz2 = 2'b10; s2 = 1'b0; a2 = 32'h10; d2 = 32'h0;
            end else begin
                // Disturb inputs while busy; must not affect the access
                w2 = 1'b1; sz2 = 2'b00; s2 = 1'b1; a2 = 32'h10; d2 = 32'h0;
            end
            if (rv2 === 1'b1) begin
                resp++;
                if (rd2 !== 32'hDEAD11EF || er2 !== 1'b0) bad++;
            end
        end
        v2 = 1'b0;
        n_checks++; if (acc != 3) $display("FAIL b2b_accepts got %0d exp 3", acc); else n_pass++;
        n_checks++; if (last_acc != 10) $display("FAIL b2b_spacing got %0d exp 10", last_acc); else n_pass++;
        n_checks++; if (resp != 3) $display("FAIL b2b_responses got %0d exp 3", resp); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL b2b_resp_data got %0d bad exp 0", bad); else n_pass++;
        req2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hDEAD11EF) $display("FAIL b2b_rb got %h exp dead11ef", rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat, seen, g;
        req2(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, rd, er, lat);
        req2(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        // Abort a store with reset during WAIT
        g = 0;
        @(negedge clk);
        while (rdy2 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        w2 = 1; sz2 = 2'b10; s2 = 0; a2 = 32'h20; d2 = 32'h12345678; v2 = 1'b1;
        @(posedge clk); #1; v2 = 1'b0;
        @(negedge clk); rst2 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({rdy2, bsy2, rv2, er2, rd2} !== {4'b1000, 32'h0}) $display("FAIL mid_reset_outs got %b_%h exp 1000_00000000", {rdy2, bsy2, rv2, er2}, rd2); else n_pass++;
        @(negedge clk); rst2 = 1'b0;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (rv2 === 1'b1) seen++; end
        n_checks++; if (seen != 0) $display("FAIL mid_reset_no_resp got %0d exp 0", seen); else n_pass++;
        req2(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL mid_reset_rb got %h exp a5a5a5a5", rd); else n_pass++;
        // Reset coincident with the access edge
        g = 0;
        @(negedge clk);
        while (rdy2 !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        w2 = 1; sz2 = 2'b10; s2 = 0; a2 = 32'h20; d2 = 32'h11111111; v2 = 1'b1;
        @(posedge clk); #1; v2 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst2 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rv2 !== 1'b0) $display("FAIL resp_edge_reset_valid got %b exp 0", rv2); else n_pass++;
        @(negedge clk); rst2 = 1'b0;
        req2(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL resp_edge_reset_rb got %h exp a5a5a5a5", rd); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd;
        logic er;
        int lat;
        req0(1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, rd, er, lat);
        n_checks++; if (lat != 0) $display("FAIL zw_store_latency got %0d exp 0", lat); else n_pass++;
        n_checks++; if ({er, rd} !== {1'b0, 32'h0}) $display("FAIL zw_store_resp got %b_%h exp 0_00000000", er, rd); else n_pass++;
        req0(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0BADF00D) $display("FAIL zw_load got %h exp 0badf00d", rd); else n_pass++;
        n_checks++; if (lat != 0) $display("FAIL zw_load_latency got %0d exp 0", lat); else n_pass++;
        req0(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, rd, er, lat);
        req0(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h0BADBEEF) $display("FAIL zw_half_rb got %h exp 0badbeef", rd); else n_pass++;
        req0(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, rd, er, lat);
        n_checks++; if ({er, rd, lat} !== {1'b1, 32'h0, 32'd0}) $display("FAIL zw_misalign got %b_%h_%0d exp 1_00000000_0", er, rd, lat); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_half();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_zero_wait();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
